// File: rtl/ttl_74299.sv
// 74299-style universal shift/storage register: hold, shift either way, or
// parallel load through the shared 3-state IO bus, with end-bit serial outputs.
module ttl_74299 #(
   parameter int WIDTH      = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic             Clk,
   input  logic             Clear,
   input  logic             S0,
   input  logic             S1,
   input  logic             DS0,
   input  logic             DS7,
   input  logic             OE1_bar,
   input  logic             OE2_bar,
   inout  wire  [WIDTH-1:0] IO,
   output logic             Q0,
   output logic             Q7
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHR   = 2'b01,
      MODE_SHL   = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_e;

   // Outputs are modelled zero-delay; the timing parameters are only range-checked.
   if (WIDTH < 2) begin : g_bad_width
      $error("ttl_74299: WIDTH must be at least 2");
   end
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
      $error("ttl_74299: delays must be non-negative");
   end

   mode_e            mode;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_q;
   logic             io_oe;

   assign mode = mode_e'({S1, S0});

   always_comb begin
      r_d = r_q;
      unique case (mode)
         MODE_HOLD: r_d = r_q;
         MODE_SHR:  r_d = {r_q[WIDTH-2:0], DS0};
         MODE_SHL:  r_d = {DS7, r_q[WIDTH-1:1]};
         MODE_LOAD: r_d = IO;
         default:   r_d = r_q;
      endcase
   end

   always_ff @(posedge Clk or posedge Clear) begin
      if (Clear) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   // Load mode always releases the bus so an external source can drive it.
   assign io_oe = ~OE1_bar & ~OE2_bar & (mode != MODE_LOAD);
   assign IO    = io_oe ? r_q : 'z;
   assign Q0    = r_q[0];
   assign Q7    = r_q[WIDTH-1];

endmodule

// File: tb/tb_ttl_74299.sv
// Directed vector bench for ttl_74299: table of mode/enable vectors plus
// hand-written async-clear and serial-loopback sequences.
module tb_ttl_74299;

   logic       clk = 1'b0;
   logic       clear, s0, s1, ds0_tb, ds7, oe1_bar, oe2_bar;
   logic       drv_en;
   logic [7:0] drv_val;
   logic       loop_en;
   logic       ds0;
   wire  [7:0] io;
   logic       q0, q7;

   int passed = 0;
   int total  = 0;

   assign io  = drv_en ? drv_val : 'z;
   assign ds0 = loop_en ? q7 : ds0_tb;

   ttl_74299 #(.WIDTH(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
      .Clk    (clk),
      .Clear  (clear),
      .S0     (s0),
      .S1     (s1),
      .DS0    (ds0),
      .DS7    (ds7),
      .OE1_bar(oe1_bar),
      .OE2_bar(oe2_bar),
      .IO     (io),
      .Q0     (q0),
      .Q7     (q7)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic [1:0] s;
      logic       ds0;
      logic       ds7;
      logic       oe1b;
      logic       oe2b;
      logic       drv;
      logic [7:0] dval;
      int         edges;
      logic [7:0] eio;
      logic       eq0;
      logic       eq7;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [7:0] eio,
                        input logic eq0, input logic eq7);
      total++;
      if (io !== eio || q0 !== eq0 || q7 !== eq7) begin
         $display("FAIL %s: got io=%h q0=%b q7=%b, expected io=%h q0=%b q7=%b",
                  name, io, q0, q7, eio, eq0, eq7);
      end else begin
         passed++;
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] s);
      s1 = s[1];
      s0 = s[0];
   endtask

   initial begin
      clear = 1'b1; s0 = 1'b0; s1 = 1'b0; ds0_tb = 1'b0; ds7 = 1'b0;
      oe1_bar = 1'b0; oe2_bar = 1'b0; drv_en = 1'b0; drv_val = '0; loop_en = 1'b0;

      //          clr s      ds0   ds7   oe1b  oe2b  drv   dval   edg eio    q0    q7
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 8'hA5, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'hA5, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1, 8'h81, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 8'h08, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5, 8'h1F, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1, 8'h81, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'hC0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7, 8'h01, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 8'h3C, 1'b0, 1'b0};
      // Released bus shows only the bench driver; a DUT driver would corrupt it.
      vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 0, 8'hC3, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 0, 8'hC3, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h3C, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 0, 8'h5A, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4, 8'h3C, 1'b0, 1'b0};

      for (int i = 0; i < 16; i++) begin
         clear   = vecs[i].clr;
         set_mode(vecs[i].s);
         ds0_tb  = vecs[i].ds0;
         ds7     = vecs[i].ds7;
         oe1_bar = vecs[i].oe1b;
         oe2_bar = vecs[i].oe2b;
         drv_en  = vecs[i].drv;
         drv_val = vecs[i].dval;
         if (vecs[i].edges > 0) edges(vecs[i].edges);
         else #1;
         check($sformatf("vec%0d", i), vecs[i].eio, vecs[i].eq0, vecs[i].eq7);
      end

      // Async clear in the middle of a shift, then an edge while held in clear.
      set_mode(2'b11); drv_en = 1'b1; drv_val = 8'hFF;
      edges(1);
      drv_en = 1'b0; set_mode(2'b01); ds0_tb = 1'b1;
      check("load_ff", 8'hFF, 1'b1, 1'b1);
      #2 clear = 1'b1;
      #1 check("clr_async", 8'h00, 1'b0, 1'b0);
      edges(1);
      check("clr_edge", 8'h00, 1'b0, 1'b0);
      clear = 1'b0;
      edges(1);
      check("clr_first", 8'h01, 1'b1, 1'b0);

      // External Q7->DS0 loopback turns shift-right into a rotation.
      set_mode(2'b11); drv_en = 1'b1; drv_val = 8'h80;
      edges(1);
      drv_en = 1'b0; set_mode(2'b01); loop_en = 1'b1;
      check("loop_load", 8'h80, 1'b0, 1'b1);
      edges(1);
      check("loop_1", 8'h01, 1'b1, 1'b0);
      edges(3);
      check("loop_4", 8'h08, 1'b0, 1'b0);
      edges(4);
      check("loop_8", 8'h80, 1'b0, 1'b1);
      loop_en = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
